decode_stage_pipelined: RTL and testbench
=========================================

// Module: decode_stage_pipelined
// PURPOSE
//  Decode stage with a registered ID/EX output, valid/ready handshakes, WB->ID bypass, load-use stall and flush.
//  Sits between fetch and execute. Uses register_file and control internally; immediate via common::immediate_extension.
//  Adds stall/flush/bypass behaviour, a stall performance counter and width parametrisation.
// PARAMETERS
//  XLEN        32  datapath width (register data, immediate, pc)
//  REG_ADDR_W  5   register index width (2**REG_ADDR_W registers, x0 hardwired 0)
//  BYPASS_EN   1   1: same-cycle WB write forwarded to read data; 0: raw register file read
//  CNT_W       32  width of stall_count (saturating)
// PORTS
//  clk             in   1           clock, rising edge
//  reset_n         in   1           asynchronous reset, active low
//  in_valid        in   1           fetch presents an instruction
//  in_ready        out  1           decode accepts this cycle (combinational)
//  in_instruction  in   instruction_type  instruction word
//  in_pc           in   XLEN        pc of in_instruction
//  flush           in   1           kill ID/EX contents and refuse input this cycle
//  wb_write_en     in   1           writeback register write enable
//  wb_write_id     in   REG_ADDR_W  writeback destination
//  wb_write_data   in   XLEN        writeback data
//  out_valid       out  1           ID/EX register holds a valid instruction
//  out_ready       in   1           execute consumes ID/EX this cycle
//  out_pc          out  XLEN        registered pc
//  out_rd_id/out_rs1_id/out_rs2_id  out  REG_ADDR_W  registered indices (rs ids feed EX forwarding)
//  out_read_data1/2  out XLEN       registered operands
//  out_immediate   out  XLEN        registered sign-extended immediate
//  out_control     out  control_type  registered control word
//  stall_count     out  CNT_W       cycles lost to load-use stalls
// BEHAVIOUR
//  Reset (async, reset_n=0): out_valid=0; all out_* and stall_count = 0; register file cleared.
//  Accept = in_valid & in_ready. Accepted instruction appears on out_* the next cycle with out_valid=1 (latency 1).
//  advance = ~out_valid | out_ready. ID/EX loads only when advance=1; otherwise it holds all fields stable.
//  Read use: rs1 used unless encoding is U_TYPE or J_TYPE; rs2 used only for R_TYPE, S_TYPE, B_TYPE.
//  hazard = out_valid & out_control.mem_read & out_rd_id!=0 & ((rs1 used & rs1==out_rd_id) | (rs2 used & rs2==out_rd_id)).
//  in_ready = advance & ~hazard & ~flush.
//  Hazard with advance=1: load moves to EX; ID/EX loads a bubble (out_valid=0); instruction is re-presented and accepted next cycle.
//  Hazard with out_ready=0: plain hold; no bubble.
//  stall_count += 1 on each cycle with in_valid & hazard; saturates at all-ones.
//  Flush: next edge out_valid=0 regardless of out_ready; in_ready=0; flush overrides hazard and accept.
//  Bypass (BYPASS_EN=1): wb_write_en & wb_write_id==rsN & rsN!=0 -> read_dataN = wb_write_data. Write and read happen in the same cycle.
//  x0: read data always 0; writes to x0 are ignored.
//  Immediate: immediate_extension(in_instruction, control.encoding), sign-extended to XLEN.
//  Bubble or flush clears out_control to all-zero (no write, no mem), so a bubble has no side effects.
//  Reset mid-operation: in-flight ID/EX contents are discarded; in_ready is not asserted until reset_n=1.
// STRUCTURE
//  Package common: control_type.mem_read, encoding enum (R/I/S/B/U/J_TYPE), id_ex_type struct bundling the out_* fields.
//  Sub-module decode_hazard_unit (combinational): rs-use decode, hazard, in_ready.
//  register_file and control are reused unchanged.
//  register_file widths are parametrised by XLEN/REG_ADDR_W.
//  Single always_ff with async reset for ID/EX and stall_count.
// TESTING
//  1 Reset then addi x1,x0,5 with out_ready=1 -> next cycle out_valid=1, out_immediate=5, out_rd_id=1; stall_count=0.
//  2 WB writes x3=0xDEADBEEF while add x4,x3,x3 is accepted -> out_read_data1=out_read_data2=0xDEADBEEF (BYPASS_EN=1).
//  3 lw x5,0(x2), then add x6,x5,x1 -> one bubble (out_valid=0 for 1 cycle), add issues the following cycle, stall_count=1.
//  4 lw x5, then lui x5,1 (no rs use) -> no stall; back-to-back issue; stall_count unchanged.
//  5 out_ready=0 for 3 cycles with valid ID/EX -> out_* held bit-stable, in_ready=0; resumes without loss or duplication.
//  6 Flush with valid ID/EX and in_valid=1 -> out_valid=0 next cycle, instruction not accepted.
//  7 Write to x0 then read x0 -> 0.
//  8 reset_n pulsed mid-stream -> out_valid drops immediately.

Source files
------------

// File: rtl/decode_stage_pipelined_pkg.sv
// Shared types and decode helpers for the pipelined decode stage.
package decode_stage_pipelined_pkg;

    typedef logic [31:0] instruction_type;

    typedef enum logic [2:0] {
        R_TYPE,
        I_TYPE,
        S_TYPE,
        B_TYPE,
        U_TYPE,
        J_TYPE
    } encoding_type;

    // All-zero is a harmless bubble: no register write, no memory access.
    typedef struct packed {
        logic         reg_write;
        logic         mem_read;
        logic         mem_write;
        logic         mem_to_reg;
        logic         alu_src;
        logic         branch;
        logic         jump;
        encoding_type encoding;
    } control_type;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    // Main control decode from the opcode field.
    function automatic control_type control_decode(instruction_type instr);
        control_type c;
        c = '0;
        case (instr[6:0])
            OpcOp:     begin c.reg_write = 1'b1; c.encoding = R_TYPE; end
            OpcOpImm:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.encoding = I_TYPE; end
            OpcLoad:   begin
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
                c.encoding   = I_TYPE;
            end
            OpcStore:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.encoding = S_TYPE; end
            OpcBranch: begin c.branch = 1'b1; c.encoding = B_TYPE; end
            OpcLui, OpcAuipc: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.encoding = U_TYPE; end
            OpcJal:    begin c.reg_write = 1'b1; c.jump = 1'b1; c.encoding = J_TYPE; end
            OpcJalr:   begin
                c.reg_write = 1'b1;
                c.jump      = 1'b1;
                c.alu_src   = 1'b1;
                c.encoding  = I_TYPE;
            end
            default:   c = '0;
        endcase
        return c;
    endfunction

    // 32-bit sign-extended immediate for the given encoding; R_TYPE has none.
    function automatic logic [31:0] immediate_extension(instruction_type instr,
                                                        encoding_type enc);
        logic [31:0] imm;
        case (enc)
            I_TYPE:  imm = {{20{instr[31]}}, instr[31:20]};
            S_TYPE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            B_TYPE:  imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            U_TYPE:  imm = {instr[31:12], 12'b0};
            J_TYPE:  imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                            1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_pipelined_hazard_unit.sv
// Load-use hazard detection and input handshake for the decode stage.
module decode_stage_pipelined_hazard_unit
    import decode_stage_pipelined_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  encoding_type          encoding,
    input  logic                  out_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_id,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic                  advance,
    output logic                  hazard,
    output logic                  ready
);

    logic rs1_used;
    logic rs2_used;

    // Operand use by encoding, then match against a load sitting in ID/EX.
    always_comb begin
        rs1_used = (encoding != U_TYPE) && (encoding != J_TYPE);
        rs2_used = (encoding == R_TYPE) || (encoding == S_TYPE) || (encoding == B_TYPE);
        advance  = !out_valid || out_ready;
        hazard   = out_valid && ex_mem_read && (ex_rd_id != '0) &&
                   ((rs1_used && (rs1_id == ex_rd_id)) || (rs2_used && (rs2_id == ex_rd_id)));
        ready    = advance && !hazard && !flush;
    end

endmodule

// File: rtl/decode_stage_pipelined.sv
// Decode stage with registered ID/EX output, WB bypass, load-use stall and flush.
module decode_stage_pipelined
    import decode_stage_pipelined_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,   // register fields are taken from 5-bit slots
    parameter bit          BYPASS_EN  = 1'b1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  instruction_type       in_instruction,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  flush,
    input  logic                  wb_write_en,
    input  logic [REG_ADDR_W-1:0] wb_write_id,
    input  logic [XLEN-1:0]       wb_write_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [REG_ADDR_W-1:0] out_rd_id,
    output logic [REG_ADDR_W-1:0] out_rs1_id,
    output logic [REG_ADDR_W-1:0] out_rs2_id,
    output logic [XLEN-1:0]       out_read_data1,
    output logic [XLEN-1:0]       out_read_data2,
    output logic [XLEN-1:0]       out_immediate,
    output control_type           out_control,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rd_id;
        logic [REG_ADDR_W-1:0] rs1_id;
        logic [REG_ADDR_W-1:0] rs2_id;
        logic [XLEN-1:0]       read_data1;
        logic [XLEN-1:0]       read_data2;
        logic [XLEN-1:0]       immediate;
        control_type           control;
    } id_ex_type;

    id_ex_type             id_ex_q, id_ex_d;
    logic                  valid_q, valid_d;
    logic [CNT_W-1:0]      stall_q, stall_d;
    logic [XLEN-1:0]       regs_q [NumRegs];

    logic [REG_ADDR_W-1:0] rs1_id, rs2_id, rd_id;
    control_type           ctrl;
    logic signed [31:0]    imm32;
    logic [XLEN-1:0]       imm_ext;
    logic [XLEN-1:0]       read_data1, read_data2;
    logic                  advance, hazard, ready_raw;

    assign rd_id  = in_instruction[7 +: REG_ADDR_W];
    assign rs1_id = in_instruction[15 +: REG_ADDR_W];
    assign rs2_id = in_instruction[20 +: REG_ADDR_W];

    // Field decode: control word and sign-extended immediate.
    always_comb begin
        ctrl    = control_decode(in_instruction);
        imm32   = immediate_extension(in_instruction, ctrl.encoding);
        imm_ext = XLEN'(imm32);
    end

    // Register file storage; x0 is never written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NumRegs; i++) regs_q[i] <= '0;
        end else if (wb_write_en && (wb_write_id != '0)) begin
            regs_q[wb_write_id] <= wb_write_data;
        end
    end

    // Operand read with x0 forced to zero and same-cycle WB forwarding.
    always_comb begin
        read_data1 = regs_q[rs1_id];
        read_data2 = regs_q[rs2_id];
        if (rs1_id == '0) begin
            read_data1 = '0;
        end else if (BYPASS_EN && wb_write_en && (wb_write_id == rs1_id)) begin
            read_data1 = wb_write_data;
        end
        if (rs2_id == '0) begin
            read_data2 = '0;
        end else if (BYPASS_EN && wb_write_en && (wb_write_id == rs2_id)) begin
            read_data2 = wb_write_data;
        end
    end

    decode_stage_pipelined_hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .encoding    (ctrl.encoding),
        .out_valid   (valid_q),
        .ex_mem_read (id_ex_q.control.mem_read),
        .ex_rd_id    (id_ex_q.rd_id),
        .out_ready   (out_ready),
        .flush       (flush),
        .advance     (advance),
        .hazard      (hazard),
        .ready       (ready_raw)
    );

    // Held low during reset so fetch never hands over an instruction that would be lost.
    assign in_ready = ready_raw && reset_n;

    // Next ID/EX contents: flush and bubbles clear valid and control, holds keep everything.
    always_comb begin
        id_ex_d = id_ex_q;
        valid_d = valid_q;
        stall_d = stall_q;
        if (flush) begin
            valid_d         = 1'b0;
            id_ex_d.control = '0;
        end else if (advance) begin
            if (in_valid && in_ready) begin
                valid_d            = 1'b1;
                id_ex_d.pc         = in_pc;
                id_ex_d.rd_id      = rd_id;
                id_ex_d.rs1_id     = rs1_id;
                id_ex_d.rs2_id     = rs2_id;
                id_ex_d.read_data1 = read_data1;
                id_ex_d.read_data2 = read_data2;
                id_ex_d.immediate  = imm_ext;
                id_ex_d.control    = ctrl;
            end else begin
                valid_d         = 1'b0;
                id_ex_d.control = '0;
            end
        end
        if (in_valid && hazard && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // ID/EX register and saturating stall counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_ex_q <= '0;
            valid_q <= 1'b0;
            stall_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_pc         = id_ex_q.pc;
    assign out_rd_id      = id_ex_q.rd_id;
    assign out_rs1_id     = id_ex_q.rs1_id;
    assign out_rs2_id     = id_ex_q.rs2_id;
    assign out_read_data1 = id_ex_q.read_data1;
    assign out_read_data2 = id_ex_q.read_data2;
    assign out_immediate  = id_ex_q.immediate;
    assign out_control    = id_ex_q.control;
    assign stall_count    = stall_q;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_decode_stage_pipelined;
    import decode_stage_pipelined_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    instruction_type in_instruction = '0;
    logic [31:0]     in_pc = '0;
    logic            flush = 1'b0;
    logic            wb_write_en = 1'b0;
    logic [4:0]      wb_write_id = '0;
    logic [31:0]     wb_write_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_pc, out_read_data1, out_read_data2, out_immediate;
    logic [4:0]      out_rd_id, out_rs1_id, out_rs2_id;
    control_type     out_control;
    logic [31:0]     stall_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0]  pc, d1, d2, imm;
        logic [4:0]   rd, rs1, rs2;
        logic         mem_read;
        encoding_type enc;
    } exp_t;

    always #5 clk = ~clk;

    decode_stage_pipelined dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instruction (in_instruction),
        .in_pc          (in_pc),
        .flush          (flush),
        .wb_write_en    (wb_write_en),
        .wb_write_id    (wb_write_id),
        .wb_write_data  (wb_write_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_rd_id      (out_rd_id),
        .out_rs1_id     (out_rs1_id),
        .out_rs2_id     (out_rs2_id),
        .out_read_data1 (out_read_data1),
        .out_read_data2 (out_read_data2),
        .out_immediate  (out_immediate),
        .out_control    (out_control),
        .stall_count    (stall_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; wb_write_en = 1'b0; out_ready = 1'b1;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, (op == 7'h03) ? 3'b010 : 3'b000, rd, op};
    endfunction

    // Instruction format from the opcode, as the ISA defines it.
    function automatic encoding_type fmt_of(input logic [6:0] op);
        case (op)
            7'h33:               return R_TYPE;
            7'h23:               return S_TYPE;
            7'h63:               return B_TYPE;
            7'h37, 7'h17:        return U_TYPE;
            7'h6f:               return J_TYPE;
            default:             return I_TYPE;
        endcase
    endfunction

    // Immediate value assembled arithmetically from the ISA bit positions.
    function automatic logic [31:0] imm_of(input logic [31:0] ins, input encoding_type f);
        int v;
        case (f)
            I_TYPE: begin v = ins[31:20]; if (v >= 2048) v -= 4096; end
            S_TYPE: begin v = ins[31:25] * 32 + ins[11:7]; if (v >= 2048) v -= 4096; end
            B_TYPE: begin
                v = ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
                if (v >= 4096) v -= 8192;
            end
            U_TYPE: v = int'(ins[31:12]) * 4096;
            J_TYPE: begin
                v = ins[31] * 1048576 + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
                if (v >= 1048576) v -= 2097152;
            end
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_count); end
        checks++; if ({out_control, out_pc, out_immediate} !== '0) begin errors++; $display("FAIL reset_fields: got %h want 0", {out_control, out_pc, out_immediate}); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        reset_n = 1'b1; idle();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_instruction = enc_i(7'h13, 5'd1, 5'd0, 12'd5); in_pc = 32'h100;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        checks++; if (out_immediate !== 32'd5) begin errors++; $display("FAIL addi_imm: got %h want 5", out_immediate); end
        checks++; if (out_rd_id !== 5'd1 || out_pc !== 32'h100) begin errors++; $display("FAIL addi_rd_pc: got %0d/%h want 1/100", out_rd_id, out_pc); end
        checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL addi_stall: got %0d want 0", stall_count); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_bypass();
        wb_write_en = 1'b1; wb_write_id = 5'd3; wb_write_data = 32'hDEADBEEF;
        in_valid = 1'b1; in_instruction = enc_r(5'd4, 5'd3, 5'd3);
        tick();
        wb_write_en = 1'b0; in_instruction = enc_r(5'd7, 5'd3, 5'd0);
        checks++; if (out_read_data1 !== 32'hDEADBEEF || out_read_data2 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_data: got %h/%h want deadbeef", out_read_data1, out_read_data2); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_read_data1 !== 32'hDEADBEEF || out_read_data2 !== 32'd0) begin errors++; $display("FAIL regfile_read: got %h/%h want deadbeef/0", out_read_data1, out_read_data2); end
        tick();
    endtask

    task automatic test_load_use();
        in_valid = 1'b1; in_instruction = enc_i(7'h03, 5'd5, 5'd2, 12'd0);
        tick();
        in_instruction = enc_r(5'd6, 5'd5, 5'd1);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL loaduse_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_control !== '0) begin errors++; $display("FAIL loaduse_bubble: got %b/%h want 0/0", out_valid, out_control); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL loaduse_reaccept: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rd_id !== 5'd6 || out_rs1_id !== 5'd5 || out_rs2_id !== 5'd1) begin errors++; $display("FAIL loaduse_issue: got %b rd%0d rs%0d,%0d want 1 rd6 rs5,1", out_valid, out_rd_id, out_rs1_id, out_rs2_id); end
        checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL loaduse_count: got %0d want 1", stall_count); end
        tick();
    endtask

    task automatic test_no_use();
        in_valid = 1'b1; in_instruction = enc_i(7'h03, 5'd5, 5'd2, 12'd0);
        tick();
        // rs1 field of this lui happens to equal 5 but U_TYPE reads no register
        in_instruction = {20'h00028, 5'd5, 7'h37};
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lui_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rd_id !== 5'd5 || out_immediate !== 32'h00028000) begin errors++; $display("FAIL lui_issue: got %b rd%0d %h want 1 rd5 00028000", out_valid, out_rd_id, out_immediate); end
        checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL lui_count: got %0d want 1", stall_count); end
        tick();
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instruction = enc_i(7'h13, 5'd2, 5'd1, 12'd7); in_pc = 32'h200;
        tick();
        in_instruction = enc_i(7'h13, 5'd3, 5'd0, 12'd9); in_pc = 32'h204;
        repeat (3) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b want 0", in_ready); end
            checks++; if (out_valid !== 1'b1 || out_rd_id !== 5'd2 || out_immediate !== 32'd7 || out_pc !== 32'h200) begin errors++; $display("FAIL hold_stable: got %b rd%0d %h %h want 1 rd2 7 200", out_valid, out_rd_id, out_immediate, out_pc); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_resume_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rd_id !== 5'd3 || out_immediate !== 32'd9 || out_pc !== 32'h204) begin errors++; $display("FAIL hold_next: got %b rd%0d %h %h want 1 rd3 9 204", out_valid, out_rd_id, out_immediate, out_pc); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_no_dup: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instruction = enc_i(7'h13, 5'd2, 5'd1, 12'd7); in_pc = 32'h300;
        tick();
        in_instruction = enc_i(7'h13, 5'd3, 5'd0, 12'd9); in_pc = 32'h304; flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_control !== '0) begin errors++; $display("FAIL flush_kill: got %b/%h want 0/0", out_valid, out_control); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_not_accepted: got %b want 0", out_valid); end
    endtask

    task automatic test_x0();
        wb_write_en = 1'b1; wb_write_id = 5'd0; wb_write_data = 32'h1234;
        tick();
        wb_write_data = 32'h5678;
        in_valid = 1'b1; in_instruction = enc_r(5'd8, 5'd0, 5'd0);
        tick();
        wb_write_en = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_read_data1 !== 32'd0 || out_read_data2 !== 32'd0) begin errors++; $display("FAIL x0_read: got %b %h/%h want 1 0/0", out_valid, out_read_data1, out_read_data2); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instruction = enc_i(7'h13, 5'd2, 5'd1, 12'd7); in_pc = 32'h400;
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_setup: got %b want 1", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || stall_count !== 32'd0) begin errors++; $display("FAIL rmid_async: got v%b r%b s%0d want v0 r0 s0", out_valid, in_ready, stall_count); end
        tick();
        reset_n = 1'b1; out_ready = 1'b1; in_instruction = enc_r(5'd9, 5'd3, 5'd0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_read_data1 !== 32'd0) begin errors++; $display("FAIL rmid_rf_cleared: got %b %h want 1 0", out_valid, out_read_data1); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0]  regs [32];
        logic [6:0]   ops [9];
        exp_t         q[$];
        exp_t         e;
        encoding_type f;
        logic [31:0]  ins;
        logic         u1, u2, haz, adv, exp_ready;
        longint       stall_m;
        ops = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6f, 7'h67};
        for (int i = 0; i < 32; i++) regs[i] = '0;
        stall_m = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 8)];
            ins[11:7] = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            in_instruction = ins; in_pc = $urandom;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            wb_write_en = $urandom_range(0, 1);
            wb_write_id = 5'($urandom_range(0, 7));
            wb_write_data = $urandom;
            #1;
            f = fmt_of(ins[6:0]);
            u1 = (f != U_TYPE) && (f != J_TYPE);
            u2 = (f == R_TYPE) || (f == S_TYPE) || (f == B_TYPE);
            haz = (q.size() != 0) && q[0].mem_read && (q[0].rd != 0) &&
                  ((u1 && ins[19:15] == q[0].rd) || (u2 && ins[24:20] == q[0].rd));
            adv = (q.size() == 0) || out_ready;
            exp_ready = adv && !haz && !flush;
            checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready cyc%0d: got %b want %b", cyc, in_ready, exp_ready); end
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_out_valid cyc%0d: got %b want %b", cyc, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++;
                if ({out_pc, out_rd_id, out_rs1_id, out_rs2_id, out_read_data1, out_read_data2, out_immediate, out_control.mem_read, out_control.encoding} !==
                    {q[0].pc, q[0].rd, q[0].rs1, q[0].rs2, q[0].d1, q[0].d2, q[0].imm, q[0].mem_read, q[0].enc}) begin
                    errors++;
                    $display("FAIL rnd_fields cyc%0d: got %h want %h", cyc,
                             {out_pc, out_rd_id, out_rs1_id, out_rs2_id, out_read_data1, out_read_data2, out_immediate, out_control.mem_read, out_control.encoding},
                             {q[0].pc, q[0].rd, q[0].rs1, q[0].rs2, q[0].d1, q[0].d2, q[0].imm, q[0].mem_read, q[0].enc});
                end
            end else begin
                checks++; if (out_control !== '0) begin errors++; $display("FAIL rnd_bubble_ctrl cyc%0d: got %h want 0", cyc, out_control); end
            end
            e.pc = in_pc; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
            e.d1 = (e.rs1 == 0) ? 32'd0 : (wb_write_en && wb_write_id == e.rs1) ? wb_write_data : regs[e.rs1];
            e.d2 = (e.rs2 == 0) ? 32'd0 : (wb_write_en && wb_write_id == e.rs2) ? wb_write_data : regs[e.rs2];
            e.imm = imm_of(ins, f); e.mem_read = (ins[6:0] == 7'h03); e.enc = f;
            @(posedge clk);
            if (in_valid && haz && stall_m < 64'hFFFF_FFFF) stall_m++;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (in_valid && exp_ready) q.push_back(e);
            end
            if (wb_write_en && wb_write_id != 0) regs[wb_write_id] = wb_write_data;
            #1;
            checks++; if (stall_count !== 32'(stall_m)) begin errors++; $display("FAIL rnd_stall cyc%0d: got %0d want %0d", cyc, stall_count, stall_m); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_no_use();
        test_hold();
        test_flush();
        test_x0();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
